// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared scheduler state encoding and UART parity codes
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ACCEPT    = 3'd1,
    S_LOAD      = 3'd2,
    S_WAIT_ACK  = 3'd3,
    S_WAIT_DONE = 3'd4
  } sched_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  // The unused code 11 is folded onto "no parity" so the transmitter never sees it.
  function automatic logic [1:0] parity_sel(input logic [1:0] cfg);
    return (cfg == 2'b11) ? PAR_NONE : cfg;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// rtl/uart_tx_scheduler_if.sv - requester and transmitter signals of the scheduler
interface uart_tx_scheduler_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [2*NUM_REQ-1:0] parity_cfg;
  logic [7:0]           tx_data;
  logic [1:0]           tx_parity_sel;
  logic                 tx_load;
  logic                 tx_busy;
  logic [NUM_REQ-1:0]   grant;
  logic                 err_noack;

  modport master (
    input  req_valid, req_data, req_last, parity_cfg, tx_busy,
    output req_ready, tx_data, tx_parity_sel, tx_load, grant, err_noack
  );

  modport slave (
    output req_valid, req_data, req_last, parity_cfg, tx_busy,
    input  req_ready, tx_data, tx_parity_sel, tx_load, grant, err_noack
  );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - rotating-priority selector returning a one-hot grant
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);
  logic [2*N-1:0] req_rot;
  logic [2*N-1:0] gnt_rot;
  logic [N-1:0]   rot;
  logic [N-1:0]   pick;

  // Rotate ptr down to bit 0, keep the lowest set bit, then rotate it back.
  assign req_rot = {req, req} >> ptr;
  assign rot     = req_rot[N-1:0];
  assign pick    = rot & (-rot);
  assign gnt_rot = {{N{1'b0}}, pick} << ptr;
  assign grant   = gnt_rot[2*N-1:N] | gnt_rot[N-1:0];
endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin scheduler sharing one UART transmitter
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int MAX_BURST   = 16,
  parameter int ACK_TIMEOUT = 4
) (
  input logic                 clk,
  input logic                 reset,
  uart_tx_scheduler_if.master bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  sched_state_t       state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic [NUM_REQ-1:0] arb_grant;
  logic               load_q, load_d;
  logic               last_q, last_d;
  logic               err_q, err_d;
  logic [7:0]         data_q, data_d;
  logic [1:0]         par_q, par_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [BW-1:0]      burst_q, burst_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic               frame_done;

  logic               sel_valid;
  logic               sel_last;
  logic [7:0]         sel_data;
  logic [1:0]         sel_par;
  logic [PW-1:0]      gidx;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req   (bus.req_valid),
    .ptr   (ptr_q),
    .grant (arb_grant)
  );

  assign sel_valid = |(bus.req_valid & grant_q);
  assign sel_last  = |(bus.req_last & grant_q);

  always_comb begin
    sel_data = '0;
    sel_par  = '0;
    gidx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        sel_data = bus.req_data[8*i +: 8];
        sel_par  = bus.parity_cfg[2*i +: 2];
        gidx     = PW'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ready_d    = '0;
    load_d     = 1'b0;
    last_d     = last_q;
    err_d      = err_q;
    data_d     = data_q;
    par_d      = par_q;
    ptr_d      = ptr_q;
    burst_d    = burst_q;
    timer_d    = timer_q;
    frame_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (|bus.req_valid) begin
          grant_d = arb_grant;
          state_d = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        if (sel_valid && !bus.tx_busy) begin
          ready_d = grant_q;
          data_d  = sel_data;
          par_d   = parity_sel(sel_par);
          last_d  = sel_last;
          burst_d = burst_q + BW'(1);
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        load_d  = 1'b1;
        timer_d = '0;
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (bus.tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
          // A silent transmitter must not stall the other requesters.
          err_d      = 1'b1;
          frame_done = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!bus.tx_busy) frame_done = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (frame_done) begin
      if (!last_q && (burst_q < BW'(MAX_BURST))) begin
        state_d = S_ACCEPT;
      end else begin
        state_d = S_IDLE;
        grant_d = '0;
        burst_d = '0;
        ptr_d   = (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ready_q <= '0;
      load_q  <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
      par_q   <= PAR_NONE;
      ptr_q   <= '0;
      burst_q <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ready_q <= ready_d;
      load_q  <= load_d;
      last_q  <= last_d;
      err_q   <= err_d;
      data_q  <= data_d;
      par_q   <= par_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
      timer_q <= timer_d;
    end
  end

  assign bus.req_ready     = ready_q;
  assign bus.tx_load       = load_q;
  assign bus.tx_data       = data_q;
  assign bus.tx_parity_sel = par_q;
  assign bus.grant         = grant_q;
  assign bus.err_noack     = err_q;
endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter NUM_REQ, 4, number of requesters sharing the one UART transmitter.
REQ-002 Parameter MAX_BURST, 16, bytes one requester may send before it is forced to release the grant.
REQ-003 Parameter ACK_TIMEOUT, 4, cycles after tx_load within which tx_busy must assert.
REQ-004 Port clk, input, 1, sole clock; all state on its rising edge.
REQ-005 Port reset, input, 1, asynchronous active-low reset.
REQ-006 Port req_valid, input, NUM_REQ, requester i has a byte pending.
REQ-007 Port req_data, input, 8*NUM_REQ, byte of requester i at bits [8i+7:8i].
REQ-008 Port req_last, input, NUM_REQ, byte is the last of requester i's packet.
REQ-009 Port req_ready, output, NUM_REQ, one-cycle accept strobe to requester i.
REQ-010 Port parity_cfg, input, 2*NUM_REQ, per-requester parity: 00 none, 01 odd, 10 even, 11 treated as none.
REQ-011 Port tx_data, output, 8, byte presented to the transmitter.
REQ-012 Port tx_parity_sel, output, 2, parity mode for the current frame.
REQ-013 Port tx_load, output, 1, one-cycle start-frame pulse.
REQ-014 Port tx_busy, input, 1, transmitter is sending a frame.
REQ-015 Port grant, output, NUM_REQ, one-hot owner; all zero when idle.
REQ-016 Port err_noack, output, 1, sticky flag: tx_busy did not assert within ACK_TIMEOUT.

Function
REQ-017 The FSM SHALL have these states: IDLE, ACCEPT, LOAD, WAIT_ACK, WAIT_DONE.
REQ-018 IDLE: when any req_valid is set, the block SHALL select the first set bit at or after rr_ptr (wrapping NUM_REQ-1 to 0), set grant, and go to ACCEPT next cycle.
REQ-019 ACCEPT: when req_valid[g] is 1 and tx_busy is 0, the block SHALL pulse req_ready[g] for exactly one cycle, latch req_data, req_last and parity_cfg of g, increment burst_cnt, and go to LOAD; otherwise it SHALL hold.
REQ-020 LOAD: tx_load SHALL be 1 for exactly one cycle with tx_data and tx_parity_sel stable; tx_data and tx_parity_sel SHALL remain stable until WAIT_DONE exits.
REQ-021 WAIT_ACK: on tx_busy=1 the block SHALL go to WAIT_DONE; after ACK_TIMEOUT cycles without tx_busy it SHALL set err_noack and treat the frame as complete.
REQ-022 WAIT_DONE: on tx_busy=0 the frame is complete.
REQ-023 On frame complete, if latched last=0 and burst_cnt<MAX_BURST, the block SHALL keep grant and return to ACCEPT.
REQ-024 On frame complete, if latched last=1 or burst_cnt==MAX_BURST, the block SHALL clear grant and burst_cnt, set rr_ptr to g+1 modulo NUM_REQ, and go to IDLE.
REQ-025 Simultaneous requests SHALL be resolved strictly round-robin; no requester SHALL wait more than NUM_REQ-1 packets or bursts.
REQ-026 While the grant is held, req_valid of other requesters SHALL be ignored.
REQ-027 Changes to req_data or parity_cfg after the accept strobe SHALL NOT affect the frame in flight.
REQ-028 At most one req_ready bit SHALL be set in any cycle, and only the bit equal to grant.
REQ-029 Latency from req_valid in IDLE to tx_load SHALL be 3 cycles when tx_busy=0.

Reset
REQ-030 While reset=0, the block SHALL force: state IDLE, grant 0, req_ready 0, tx_load 0, tx_data 0x00, tx_parity_sel 00, err_noack 0, rr_ptr 0, burst_cnt 0, timeout counter 0.
REQ-031 Reset asserted mid-frame SHALL abandon the frame with no further tx_load or req_ready; operation SHALL resume from IDLE on the first edge after release.

Structure
REQ-032 The FSM state encoding and the parity codes (PAR_NONE, PAR_ODD, PAR_EVEN) SHALL live in the shared package uart_pkg, also used by the transmitter.
REQ-033 The round-robin selector SHALL be one sub-module, rr_arbiter (inputs req, ptr; output one-hot grant); no other sub-modules.

Verification
REQ-034 Single request: req_valid=0001, data 0x5A, last=1, parity_cfg 10 -> tx_load 3 cycles later, tx_data=0x5A, tx_parity_sel=10, grant cleared after tx_busy falls, rr_ptr=1.
REQ-035 All four valid, last=1 each -> service order 0,1,2,3, then 0 again after wrap.
REQ-036 Requester 2 sends 20 bytes, last=0 throughout, MAX_BURST=16 -> release after 16 bytes; requester 3 (pending) served next; requester 2's remaining bytes follow later.
REQ-037 tx_busy held at 0 after tx_load -> err_noack=1 after 4 cycles, FSM proceeds, flag persists until reset.
REQ-038 Reset pulled low during WAIT_DONE -> all outputs at reset values immediately; first grant after release goes to requester 0.
